pcxt_clock_enable_gen: RTL



---
 rtl/pcxt_clock_enable_gen.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pcxt_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : pcxt_clock_enable_gen
// Purpose  : Turns the PLL lock indication into a held system reset and
//            generates single-cycle CPU (4.77/7.16/9.54 MHz) and PIT
//            (1.193 MHz) clock enables from the 28.636363 MHz clock.
// Options  : PCXT_SPEED_SYNC_EN - adds a 2-flop synchroniser on speed_sel
//            for use when it is driven from another clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module pcxt_clock_enable_gen #(
   parameter int LOCK_SYNC_STAGES  = 2,
   parameter int RESET_HOLD_CYCLES = 1024,
   parameter int PIT_DIV           = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic [1:0] speed_sel,
   output logic       reset_out,
   output logic       cpu_ce,
   output logic       pit_ce,
   output logic [1:0] speed_active
);

   localparam int c_HOLD_W = $clog2(RESET_HOLD_CYCLES);
   localparam int c_PIT_W  = $clog2(PIT_DIV);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [c_PIT_W-1:0]  c_PIT_LAST  = c_PIT_W'(PIT_DIV - 1);

   // ST_START is the first reset-free cycle: speed is loaded, dividers wait.
   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [LOCK_SYNC_STAGES-1:0] r_lock_sync;
   logic                        w_locked_s;
   logic [c_HOLD_W-1:0]         r_hold_cnt;
   logic [2:0]                  r_cpu_cnt;
   logic [c_PIT_W-1:0]          r_pit_cnt;
   logic [1:0]                  r_speed_active;
   logic                        r_reset_out;
   logic [1:0]                  w_speed_in;
   logic [1:0]                  w_speed_code;
   logic [2:0]                  w_cpu_last;
   logic                        w_cpu_ce;
   logic                        w_pit_ce;

   // Bring the asynchronous lock flag into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_sync <= '0;
      end else begin
         r_lock_sync <= {r_lock_sync[LOCK_SYNC_STAGES-2:0], pll_locked};
      end
   end

   assign w_locked_s = r_lock_sync[LOCK_SYNC_STAGES-1];

`ifdef PCXT_SPEED_SYNC_EN
   logic [1:0] r_speed_meta;
   logic [1:0] r_speed_sync;

   // Two-flop synchroniser for a speed request from a foreign clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_speed_meta <= 2'b00;
         r_speed_sync <= 2'b00;
      end else begin
         r_speed_meta <= speed_sel;
         r_speed_sync <= r_speed_meta;
      end
   end

   assign w_speed_in = r_speed_sync;
`else
   assign w_speed_in = speed_sel;
`endif

   // The reserved code 11 runs at the 4.77 MHz rate and is reported as 00.
   assign w_speed_code = (w_speed_in == 2'b11) ? 2'b00 : w_speed_in;

   // Terminal count of the CPU divider for the speed currently applied.
   always_comb begin
      w_cpu_last = 3'd5;
      case (r_speed_active)
         2'b01:   w_cpu_last = 3'd3;
         2'b10:   w_cpu_last = 3'd2;
         default: w_cpu_last = 3'd5;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_HOLD;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and enable pulses; enables only fire while running.
   always_comb begin
      w_state_next = r_state;
      w_cpu_ce     = 1'b0;
      w_pit_ce     = 1'b0;
      case (r_state)
         ST_HOLD: begin
            if (w_locked_s && (r_hold_cnt == c_HOLD_LAST)) begin
               w_state_next = ST_START;
            end
         end
         ST_START: begin
            w_state_next = w_locked_s ? ST_RUN : ST_HOLD;
         end
         ST_RUN: begin
            w_cpu_ce = (r_cpu_cnt == w_cpu_last);
            w_pit_ce = (r_pit_cnt == c_PIT_LAST);
            if (!w_locked_s) begin
               w_state_next = ST_HOLD;
            end
         end
         default: begin
            w_state_next = ST_HOLD;
         end
      endcase
   end

   // Hold counter, dividers and applied speed; speed only changes on a CPU pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_cnt     <= '0;
         r_cpu_cnt      <= '0;
         r_pit_cnt      <= '0;
         r_speed_active <= 2'b00;
      end else if (w_state_next == ST_HOLD) begin
         r_cpu_cnt      <= '0;
         r_pit_cnt      <= '0;
         r_speed_active <= 2'b00;
         if ((r_state == ST_HOLD) && w_locked_s) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
         end else begin
            r_hold_cnt <= '0;
         end
      end else begin
         r_hold_cnt <= '0;
         case (r_state)
            ST_START: begin
               r_speed_active <= w_speed_code;
            end
            ST_RUN: begin
               r_cpu_cnt <= w_cpu_ce ? 3'd0 : (r_cpu_cnt + 3'd1);
               r_pit_cnt <= w_pit_ce ? '0 : (r_pit_cnt + c_PIT_W'(1));
               if (w_cpu_ce) begin
                  r_speed_active <= w_speed_code;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered reset output so it never glitches on state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reset_out <= 1'b1;
      end else begin
         r_reset_out <= (w_state_next == ST_HOLD);
      end
   end

   assign reset_out    = r_reset_out;
   assign cpu_ce       = w_cpu_ce;
   assign pit_ce       = w_pit_ce;
   assign speed_active = r_speed_active;

endmodule
`default_nettype wire
